// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction prefetch path.
package cpu_pkg;

    localparam int unsigned INSTR_W  = 32;
    // Widest supported program counter; queue entries carry this many pc bits.
    localparam int unsigned PC_W_MAX = 32;
    // funct3 encoding of a word-sized memory access.
    localparam logic [2:0]  FUNCT3_MEM_W = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DISCARD
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0]  iword;
        logic [PC_W_MAX-1:0] pc;
    } iq_entry_t;

endpackage

// File: rtl/iq_fifo.sv
// Synchronous FIFO of prefetched {iword, pc} entries with push/pop/flush.
// Flush wins over push and pop in the same cycle.
module iq_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push,
    input  iq_entry_t                    i_data,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output iq_entry_t                    o_head,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    iq_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_cnt;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign w_pop  = i_pop & (r_cnt != '0) & ~i_flush;
    assign w_push = i_push & ~i_flush & ((r_cnt != CNT_W'(DEPTH)) | w_pop);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= ptr_inc(r_wr);
            if (w_pop)  r_rd <= ptr_inc(r_rd);
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Entry storage; contents are only observed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    assign o_head  = r_mem[r_rd];
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: keeps a DEPTH-entry queue of fetched {iword, pc}, issues
// one word fetch at a time ahead of execution, yields the memory port to load/store
// traffic and flushes on control-flow redirects.
// Optional feature macro PREFETCH_BYPASS_EN: when defined, a word returning into an empty
// queue is presented on iq_* in the same cycle (zero-cycle latency).
module prefetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned    PC_W     = 16,
    parameter int unsigned    DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               data_req,
    output logic               fetch_idle,
    output logic               iq_valid,
    output logic [INSTR_W-1:0] iq_iword,
    output logic [PC_W-1:0]    iq_pc,
    input  logic               iq_ready,
    output logic               pc_misaligned,
    output logic               mem_ce,
    output logic [PC_W-1:0]    mem_addr,
    input  logic               mem_busy,
    input  logic               mem_valid,
    input  logic [INSTR_W-1:0] mem_dataout
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_state_t     r_state;
    fetch_state_t     w_state_next;
    logic [PC_W-1:0]  r_fetch_pc;
    logic             r_misaligned;

    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_resp;
    logic             w_bypass;
    logic             w_push;
    logic             w_pop;
    logic             w_can_issue;
    iq_entry_t        w_head;
    iq_entry_t        w_push_entry;
    logic             w_unused_pc_hi;

    // A returning word is kept only if no redirect arrives alongside it.
    assign w_resp = (r_state == WAIT) & mem_valid & ~redirect;

`ifdef PREFETCH_BYPASS_EN
    assign w_bypass = w_resp & w_empty;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word consumed in the same cycle never enters the queue.
    assign w_push      = w_resp & ~(w_bypass & iq_ready);
    assign w_pop       = iq_ready & ~w_empty & ~redirect;
    assign w_can_issue = (w_count < CNT_W'(DEPTH)) & ~data_req & ~mem_busy
                         & ~r_misaligned & ~redirect;

    assign w_push_entry.iword = mem_dataout;
    assign w_push_entry.pc    = PC_W_MAX'(r_fetch_pc);

    iq_fifo #(
        .DEPTH (DEPTH)
    ) u_iq_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Upper pc bits of a queue entry are zero when PC_W < PC_W_MAX.
    assign w_unused_pc_hi = ^w_head.pc;

    // Fetch state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Fetch sequencing: one outstanding access, 1-cycle strobe, late data dropped after redirect.
    always_comb begin
        w_state_next = r_state;
        mem_ce       = 1'b0;
        fetch_idle   = 1'b0;
        case (r_state)
            IDLE: begin
                fetch_idle = 1'b1;
                if (w_can_issue) w_state_next = ISSUE;
            end
            ISSUE: begin
                mem_ce       = 1'b1;
                w_state_next = redirect ? DISCARD : WAIT;
            end
            WAIT: begin
                if (mem_valid) begin
                    w_state_next = IDLE;
                end else if (redirect) begin
                    w_state_next = DISCARD;
                end
            end
            DISCARD: begin
                if (mem_valid) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Fetch address and sticky misalignment flag; a redirect overrides a same-cycle advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc   <= RESET_PC;
            r_misaligned <= 1'b0;
        end else if (redirect) begin
            r_fetch_pc   <= redirect_pc;
            r_misaligned <= |redirect_pc[1:0];
        end else if (w_resp) begin
            r_fetch_pc   <= r_fetch_pc + PC_W'(4);
        end
    end

    // Head of queue, or the bypassed word when the queue is empty.
    always_comb begin
        iq_iword = '0;
        iq_pc    = '0;
        if (!w_empty) begin
            iq_iword = w_head.iword;
            iq_pc    = w_head.pc[PC_W-1:0];
        end else if (w_bypass) begin
            iq_iword = mem_dataout;
            iq_pc    = r_fetch_pc;
        end
    end

    assign iq_valid      = ~w_empty | w_bypass;
    assign mem_addr      = r_fetch_pc;
    assign pc_misaligned = r_misaligned;

endmodule

// File: tb/tb_prefetch_unit.sv
// Self-checking bench for prefetch_unit: a word-memory responder plus a transaction-level
// reference (expected fetch address, queue of delivered words, sticky misalignment flag).
module tb_prefetch_unit;

    localparam int unsigned PC_W     = 16;
    localparam int unsigned DEPTH    = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;
`ifdef PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        data_req;
    logic        fetch_idle;
    logic        iq_valid;
    logic [31:0] iq_iword;
    logic [15:0] iq_pc;
    logic        iq_ready;
    logic        pc_misaligned;
    logic        mem_ce;
    logic [15:0] mem_addr;
    logic        mem_busy;
    logic        mem_valid;
    logic [31:0] mem_dataout;

    prefetch_unit #(
        .PC_W     (PC_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .data_req      (data_req),
        .fetch_idle    (fetch_idle),
        .iq_valid      (iq_valid),
        .iq_iword      (iq_iword),
        .iq_pc         (iq_pc),
        .iq_ready      (iq_ready),
        .pc_misaligned (pc_misaligned),
        .mem_ce        (mem_ce),
        .mem_addr      (mem_addr),
        .mem_busy      (mem_busy),
        .mem_valid     (mem_valid),
        .mem_dataout   (mem_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic [15:0] pc;
    } ent_t;

    // Reference state
    ent_t        m_q[$];
    logic [15:0] m_fpc;
    bit          m_mis;
    // Memory responder state
    bit          mp, mlive, morphan;
    int          mcnt, lat;
    logic [15:0] maddr;
    logic [31:0] mdata;
    // Previous-cycle inputs (gate the next issue)
    bit          prev_dreq, prev_red, prev_busy, prev_iqv;
    // Per-test log
    int          cyc, n_ce, n_pop, rise_cyc, first_mv_cyc;
    logic [15:0] ce_addr_q[$];
    int          ce_cyc_q[$];
    logic [15:0] first_pc;
    int          n_cmp, n_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ce_addr(input int i);
        if (i < ce_addr_q.size()) return ce_addr_q[i];
        return 16'hdead;
    endfunction

    function automatic int ce_cyc(input int i);
        if (i < ce_cyc_q.size()) return ce_cyc_q[i];
        return -1;
    endfunction

    task automatic clear_log();
        cyc = 0; n_ce = 0; n_pop = 0; rise_cyc = -1; first_mv_cyc = -1; prev_iqv = 0;
        first_pc = 16'hxxxx;
        ce_addr_q.delete();
        ce_cyc_q.delete();
    endtask

    // One clock cycle: drive memory outputs, check DUT outputs, advance reference.
    task automatic step();
        bit   mv, resp, expv;
        ent_t e;
        mv          = mp && (mcnt == 0);
        mem_valid   = mv;
        mem_busy    = mp && (mcnt != 0);
        mem_dataout = mv ? mdata : $urandom;
        #1;
        if (!reset) begin
            chk("rst_iq_valid", iq_valid, 1'b0);
            chk("rst_iq_iword", iq_iword, 32'h0);
            chk("rst_iq_pc", iq_pc, 16'h0);
            chk("rst_mem_ce", mem_ce, 1'b0);
            chk("rst_fetch_idle", fetch_idle, 1'b1);
            chk("rst_pc_misaligned", pc_misaligned, 1'b0);
        end else begin
            resp = mv && mlive && !redirect;
            expv = (m_q.size() != 0) || (BYP && resp);
            chk("iq_valid", iq_valid, expv);
            if (expv) begin
                if (m_q.size() != 0) begin
                    e = m_q[0];
                end else begin
                    e.w = mdata; e.pc = maddr;
                end
                chk("iq_pc", iq_pc, e.pc);
                chk("iq_iword", iq_iword, e.w);
            end
            chk("fetch_idle", fetch_idle, !(mem_ce || (mp && !morphan)));
            chk("pc_misaligned", pc_misaligned, m_mis);
            if (mem_ce) begin
                chk("mem_addr", mem_addr, m_fpc);
                chk("issue_while_outstanding", mp, 1'b0);
                chk("issue_after_data_req", prev_dreq, 1'b0);
                chk("issue_after_busy", prev_busy, 1'b0);
                chk("issue_after_redirect", prev_red, 1'b0);
                chk("issue_while_misaligned", m_mis, 1'b0);
                chk("issue_queue_room", m_q.size() < DEPTH, 1'b1);
                n_ce++;
                ce_addr_q.push_back(mem_addr);
                ce_cyc_q.push_back(cyc);
            end
            if (mv && first_mv_cyc < 0) first_mv_cyc = cyc;
            if (iq_valid && !prev_iqv && rise_cyc < 0) begin
                rise_cyc = cyc;
                first_pc = iq_pc;
            end
            prev_iqv = iq_valid;
            if (resp) begin
                e.w = mdata; e.pc = maddr;
                m_q.push_back(e);
                m_fpc = m_fpc + 16'd4;
            end
            if (iq_ready && expv && !redirect) begin
                void'(m_q.pop_front());
                n_pop++;
            end
            if (redirect) begin
                m_q.delete();
                m_fpc = redirect_pc;
                m_mis = (redirect_pc[1:0] != 2'b00);
                mlive = 0;
            end
            prev_dreq = data_req;
            prev_red  = redirect;
            prev_busy = mem_busy;
            cyc++;
        end
        if (mv) mp = 0;
        else if (mp) mcnt--;
        if (reset && mem_ce) begin
            mp = 1; mcnt = lat - 1; maddr = mem_addr; mdata = $urandom;
            mlive = !redirect; morphan = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0; redirect = 1'b0; data_req = 1'b0; iq_ready = 1'b0;
        m_q.delete(); m_fpc = RESET_PC; m_mis = 0;
        if (mp) morphan = 1;
        mlive = 0;
        prev_dreq = 0; prev_red = 0; prev_busy = 0;
        repeat (n) step();
        reset = 1'b1;
        clear_log();
    endtask

    task automatic pulse(input logic [15:0] pc);
        redirect = 1'b1; redirect_pc = pc;
        step();
        redirect = 1'b0;
    endtask

    task automatic run_until_ce(input int target, input int budget);
        int b;
        b = budget;
        while (n_ce < target && b > 0) begin
            step();
            b--;
        end
        chk("ce_count_reached", n_ce, target);
    endtask

    initial begin
        logic [31:0] rv;
        int b;
        n_cmp = 0; n_err = 0;
        mp = 0; mlive = 0; morphan = 0; mcnt = 0; maddr = '0; mdata = '0;
        reset = 1'b0; redirect = 1'b0; redirect_pc = '0; data_req = 1'b0; iq_ready = 1'b0;
        mem_valid = 1'b0; mem_busy = 1'b0; mem_dataout = '0;
        lat = 3;
        @(negedge clk);

        // T1: first fetch right after release, 3-cycle memory
        do_reset(3);
        lat = 3;
        run_until_ce(2, 20);
        chk("T1_first_ce_cycle", ce_cyc(0), 1);
        chk("T1_first_addr", ce_addr(0), 16'h0000);
        chk("T1_second_addr", ce_addr(1), 16'h0004);
        chk("T1_second_ce_cycle", ce_cyc(1), 6);
        chk("T1_first_iq_pc", first_pc, 16'h0000);
        chk("T1_latency", rise_cyc - first_mv_cyc, BYP ? 0 : 1);

        // T2: queue fills, fetching stops; one pop frees one slot
        repeat (30) step();
        chk("T2_fetch_count", n_ce, 2);
        chk("T2_idle", fetch_idle, 1'b1);
        chk("T2_no_ce", mem_ce, 1'b0);
        iq_ready = 1'b1;
        step();
        iq_ready = 1'b0;
        run_until_ce(3, 20);
        chk("T2_third_addr", ce_addr(2), 16'h0008);
        repeat (10) step();

        // T3: redirect during WAIT discards the returning word
        do_reset(2);
        lat = 5; iq_ready = 1'b1;
        run_until_ce(1, 10);
        step(); step();
        pulse(16'h0100);
        run_until_ce(2, 20);
        chk("T3_redirect_addr", ce_addr(1), 16'h0100);
        b = 30;
        while (rise_cyc < 0 && b > 0) begin step(); b--; end
        chk("T3_first_iq_pc", first_pc, 16'h0100);

        // T4: data_req during WAIT lets the access finish, then holds off fetches
        do_reset(2);
        lat = 3; iq_ready = 1'b1;
        run_until_ce(1, 10);
        step();
        data_req = 1'b1;
        repeat (10) step();
        chk("T4_no_fetch", n_ce, 1);
        chk("T4_idle", fetch_idle, 1'b1);
        data_req = 1'b0;
        run_until_ce(2, 10);
        chk("T4_resume_addr", ce_addr(1), 16'h0004);

        // T5: misaligned redirect blocks fetching until an aligned one
        do_reset(2);
        lat = 2; iq_ready = 1'b1;
        pulse(16'h0102);
        repeat (10) step();
        chk("T5_no_fetch", n_ce, 0);
        chk("T5_flag", pc_misaligned, 1'b1);
        pulse(16'h0200);
        run_until_ce(1, 10);
        chk("T5_addr", ce_addr(0), 16'h0200);
        chk("T5_flag_clear", pc_misaligned, 1'b0);

        // T6: address wrap at the top of the PC space
        do_reset(2);
        lat = 2; iq_ready = 1'b0;
        pulse(16'hFFFC);
        run_until_ce(2, 30);
        chk("T6_addr0", ce_addr(0), 16'hFFFC);
        chk("T6_addr1", ce_addr(1), 16'h0000);
        chk("T6_first_iq_pc", first_pc, 16'hFFFC);
        chk("T6_latency", rise_cyc - first_mv_cyc, BYP ? 0 : 1);

        // T7: reset mid-access; the late response after release is ignored
        do_reset(2);
        lat = 8; iq_ready = 1'b1;
        run_until_ce(1, 10);
        step(); step();
        do_reset(2);
        lat = 2; iq_ready = 1'b1;
        run_until_ce(1, 20);
        chk("T7_orphan_mv_cycle", first_mv_cyc, 3);
        chk("T7_ce_cycle", ce_cyc(0), 4);
        chk("T7_addr", ce_addr(0), RESET_PC);
        repeat (10) step();

        // Randomized traffic against the reference
        do_reset(2);
        for (int i = 0; i < 1500; i++) begin
            lat      = $urandom_range(1, 4);
            iq_ready = ($urandom % 2) == 0;
            data_req = ($urandom % 5) == 0;
            if (($urandom % 30) == 0) begin
                rv = $urandom;
                redirect_pc = rv[15:0];
                if (rv[17:16] != 2'b00) redirect_pc[1:0] = 2'b00;
                redirect = 1'b1;
            end
            step();
            redirect = 1'b0;
        end
        chk("rand_progress", n_pop >= 20, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
